// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EX pipeline register: control bundle, bubble value and default widths.
package pipe_pkg;

  localparam int PIPE_DATA_W     = 16;
  localparam int PIPE_REG_ADDR_W = 4;
  localparam int PIPE_ALUOP_W    = 3;
  localparam int PIPE_CNT_W      = 16;

  typedef struct packed {
    logic                    regwrite;
    logic                    memread;
    logic                    memwrite;
    logic                    branch;
    logic                    memtoreg;
    logic                    regdst;
    logic [PIPE_ALUOP_W-1:0] aluop;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  // Side-effect controls must never reach EX without a real instruction behind them.
  function automatic id_ex_ctrl_t gate_ctrl(input id_ex_ctrl_t c, input logic valid);
    id_ex_ctrl_t g;
    g = c;
    if (!valid) begin
      g.regwrite = 1'b0;
      g.memread  = 1'b0;
      g.memwrite = 1'b0;
      g.branch   = 1'b0;
      g.memtoreg = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment, no wrap at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid tracking, stall/flush, pre-resolved write destination
// and saturating stall/bubble counters. Priority per edge: flush > stall > load.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
  parameter int ALUOP_W    = PIPE_ALUOP_W,
  parameter int CNT_W      = PIPE_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  input  logic                  regwrite,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic                  branch,
  input  logic                  memtoreg,
  input  logic                  regdst,
  input  logic [ALUOP_W-1:0]    aluop,
  input  logic [DATA_W-1:0]     data1,
  input  logic [DATA_W-1:0]     data2,
  input  logic [DATA_W-1:0]     offset,
  input  logic [REG_ADDR_W-1:0] regdest1,
  input  logic [REG_ADDR_W-1:0] regdest2,
  output logic                  out_valid,
  output logic                  regwrite_out,
  output logic                  memread_out,
  output logic                  memwrite_out,
  output logic                  branch_out,
  output logic                  memtoreg_out,
  output logic                  regdst_out,
  output logic [ALUOP_W-1:0]    aluop_out,
  output logic [DATA_W-1:0]     data1_out,
  output logic [DATA_W-1:0]     data2_out,
  output logic [DATA_W-1:0]     offset_out,
  output logic [REG_ADDR_W-1:0] regdest1_out,
  output logic [REG_ADDR_W-1:0] regdest2_out,
  output logic [REG_ADDR_W-1:0] wr_reg_out,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  id_ex_ctrl_t ctrl_in;
  id_ex_ctrl_t ctrl_q;
  logic        valid_q;

  assign ctrl_in = '{regwrite: regwrite, memread: memread, memwrite: memwrite,
                     branch: branch, memtoreg: memtoreg, regdst: regdst, aluop: aluop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      ctrl_q       <= CTRL_BUBBLE;
      data1_out    <= '0;
      data2_out    <= '0;
      offset_out   <= '0;
      regdest1_out <= '0;
      regdest2_out <= '0;
      wr_reg_out   <= '0;
    end else if (flush) begin
      // Data, destinations and aluop hold so a bubble does not toggle the wide buses.
      valid_q <= 1'b0;
      ctrl_q  <= '{aluop: ctrl_q.aluop, default: 1'b0};
    end else if (!stall) begin
      valid_q      <= in_valid;
      ctrl_q       <= gate_ctrl(ctrl_in, in_valid);
      data1_out    <= data1;
      data2_out    <= data2;
      offset_out   <= offset;
      regdest1_out <= regdest1;
      regdest2_out <= regdest2;
      wr_reg_out   <= regdst ? regdest2 : regdest1;
    end
  end

  assign out_valid    = valid_q;
  assign regwrite_out = ctrl_q.regwrite;
  assign memread_out  = ctrl_q.memread;
  assign memwrite_out = ctrl_q.memwrite;
  assign branch_out   = ctrl_q.branch;
  assign memtoreg_out = ctrl_q.memtoreg;
  assign regdst_out   = ctrl_q.regdst;
  assign aluop_out    = ctrl_q.aluop;

  // A bubble is produced whenever the edge leaves out_valid low: flush, or a load of an invalid slot.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (stall & ~flush),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (flush | (~stall & ~in_valid)),
    .count (bubble_cnt)
  );

endmodule
